// File: rtl/sync_decade_counter.sv
`default_nettype none
// ============================================================================
// Module   : sync_decade_counter
// Purpose  : Cascaded BCD up/down counter. A prescaler running on clk
//            produces a clock enable, so no divided clock exists. Every
//            step moves the whole BCD value by one. A registered tick marks
//            each step. A registered tc marks each wrap.
// Ports    : clk      - single clock, rising edge
//            rst      - asynchronous reset, active low
//            en       - count enable (gates prescaler and counting)
//            up_dn    - 1 = increment, 0 = decrement (sampled on steps)
//            clr      - synchronous clear of digits and prescaler
//            load     - synchronous parallel load (nibbles > 9 load as 9)
//            load_val - BCD load value, digit i in [4i+3:4i]
//            q        - BCD count, digit 0 in [3:0]
//            tick     - one-cycle strobe after each step edge
//            tc       - one-cycle strobe coincident with the wrapped value
// Revision : 1.0 - initial release
// ============================================================================
module sync_decade_counter #(
  parameter int DIGITS   = 4,
  parameter int TICK_DIV = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clr,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   q,
  output logic                  tick,
  output logic                  tc
);

  localparam int            PW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] C_PRESC_MAX = PW'(TICK_DIV - 1);
  localparam logic [3:0]    C_NINE      = 4'd9;

  logic [PW-1:0]         presc_q, presc_d;
  logic [4*DIGITS-1:0]   cnt_q, cnt_d;
  logic                  tick_q, tick_d;
  logic                  tc_q, tc_d;

  logic [4*DIGITS-1:0]   load_sat;
  logic [4*DIGITS-1:0]   step_val;
  logic                  chain;
  logic                  wrap;
  logic [3:0]            digit;
  logic                  step;

  // Out-of-range load nibbles clamp to 9 so every digit stays in 0..9.
  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_sat
      assign load_sat[4*g +: 4] = (load_val[4*g +: 4] > C_NINE) ? C_NINE
                                                                : load_val[4*g +: 4];
    end
  endgenerate

  assign step = en && (presc_q == C_PRESC_MAX);

  // Ripple the carry/borrow enable through the digits combinationally.
  // chain is 1 at digit i when all lower digits are 9 (up) or 0 (down);
  // after the last digit it is the wrap condition.
  always_comb begin
    step_val = cnt_q;
    chain    = 1'b1;
    digit    = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      digit = cnt_q[4*i +: 4];
      if (chain) begin
        if (up_dn) step_val[4*i +: 4] = (digit == C_NINE) ? 4'd0 : digit + 4'd1;
        else       step_val[4*i +: 4] = (digit == 4'd0)   ? C_NINE : digit - 4'd1;
      end
      chain = chain & (up_dn ? (digit == C_NINE) : (digit == 4'd0));
    end
    wrap = chain;
  end

  // Next state: clr > load > step. Strobes default low, so they only
  // ever last one cycle.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    tc_d    = 1'b0;
    if (clr) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (load) begin
      presc_d = '0;
      cnt_d   = load_sat;
    end else if (en) begin
      if (step) begin
        presc_d = '0;
        cnt_d   = step_val;
        tick_d  = 1'b1;
        tc_d    = wrap;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      tc_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      tc_q    <= tc_d;
    end
  end

  assign q    = cnt_q;
  assign tick = tick_q;
  assign tc   = tc_q;

endmodule
`default_nettype wire

// File: tb/tb_sync_decade_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_decade_counter
// Purpose  : Self-checking bench for sync_decade_counter. The main instance
//            (DIGITS=4, TICK_DIV=10) is checked against an integer
//            reference model. A second instance (DIGITS=2, TICK_DIV=1)
//            covers the every-cycle step case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_decade_counter;

  localparam int DIGITS   = 4;
  localparam int TICK_DIV = 10;
  localparam int MOD      = 10000;

  logic        clk = 1'b0;
  logic        rst, en, up_dn, clr, load;
  logic [15:0] load_val;
  logic [15:0] q;
  logic        tick, tc;

  logic        rst2, en2, up_dn2, clr2, load2;
  logic [7:0]  load_val2;
  logic [7:0]  q2;
  logic        tick2, tc2;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: the count is a plain integer.
  int m_cnt, m_pre;
  bit m_tick, m_tc;

  always #5 clk = ~clk;

  sync_decade_counter #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) u_dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clr(clr), .load(load),
    .load_val(load_val), .q(q), .tick(tick), .tc(tc)
  );

  sync_decade_counter #(.DIGITS(2), .TICK_DIV(1)) u_dut2 (
    .clk(clk), .rst(rst2), .en(en2), .up_dn(up_dn2), .clr(clr2), .load(load2),
    .load_val(load_val2), .q(q2), .tick(tick2), .tc(tc2)
  );

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int          x;
    x = v;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic int sat_value(input logic [15:0] b);
    int v, w, n;
    v = 0;
    w = 1;
    for (int i = 0; i < DIGITS; i++) begin
      n = int'(b[4*i +: 4]);
      if (n > 9) n = 9;
      v = v + n * w;
      w = w * 10;
    end
    return v;
  endfunction

  // Apply the current inputs to the model, then advance one clock edge and
  // move to a sampling point 1 time unit after it.
  task automatic model_clock();
    m_tick = 1'b0;
    m_tc   = 1'b0;
    if (clr) begin
      m_cnt = 0;
      m_pre = 0;
    end else if (load) begin
      m_cnt = sat_value(load_val);
      m_pre = 0;
    end else if (en) begin
      if (m_pre == TICK_DIV - 1) begin
        m_pre  = 0;
        m_tick = 1'b1;
        if (up_dn) begin
          m_tc  = (m_cnt == MOD - 1);
          m_cnt = (m_cnt + 1) % MOD;
        end else begin
          m_tc  = (m_cnt == 0);
          m_cnt = (m_cnt + MOD - 1) % MOD;
        end
      end else begin
        m_pre = m_pre + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [15:0] v);
    load     = 1'b1;
    load_val = v;
    en       = 1'b0;
    model_clock();
    load     = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (q !== 16'h0000 || tick !== 1'b0 || tc !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state q=%h tick=%b tc=%b required q=0000 tick=0 tc=0", q, tick, tc);
    end
    m_cnt = 0; m_pre = 0; m_tick = 0; m_tc = 0;
    @(negedge clk);
    rst = 1'b1;
    model_clock();
  endtask

  task automatic test_up_count();
    int ticks, last, tc_seen;
    ticks = 0; last = -1; tc_seen = 0;
    en = 1'b1; up_dn = 1'b1;
    for (int c = 1; c <= 100; c++) begin
      model_clock();
      if (tick === 1'b1) begin
        n_checks++;
        if (last >= 0 && c - last != TICK_DIV) begin
          n_errors++;
          $display("FAIL up_tick_spacing got=%0d required=%0d", c - last, TICK_DIV);
        end
        last = c;
        ticks++;
      end
      if (tc === 1'b1) tc_seen++;
    end
    en = 1'b0;
    n_checks++;
    if (q !== 16'h0010) begin
      n_errors++;
      $display("FAIL up_count_q got=%h required=0010", q);
    end
    n_checks++;
    if (ticks != 10) begin
      n_errors++;
      $display("FAIL up_tick_count got=%0d required=10", ticks);
    end
    n_checks++;
    if (tc_seen != 0) begin
      n_errors++;
      $display("FAIL up_tc_never got=%0d required=0", tc_seen);
    end
  endtask

  task automatic test_up_wrap();
    do_load(16'h9999);
    en = 1'b1; up_dn = 1'b1;
    repeat (10) model_clock();
    en = 1'b0;
    n_checks++;
    if (q !== 16'h0000 || tc !== 1'b1 || tick !== 1'b1) begin
      n_errors++;
      $display("FAIL up_wrap q=%h tc=%b tick=%b required q=0000 tc=1 tick=1", q, tc, tick);
    end
    model_clock();
    n_checks++;
    if (tc !== 1'b0 || tick !== 1'b0 || q !== 16'h0000) begin
      n_errors++;
      $display("FAIL up_wrap_one_cycle q=%h tc=%b tick=%b required q=0000 tc=0 tick=0", q, tc, tick);
    end
  endtask

  task automatic test_down_borrow();
    do_load(16'h1000);
    en = 1'b1; up_dn = 1'b0;
    repeat (10) model_clock();
    en = 1'b0;
    n_checks++;
    if (q !== 16'h0999 || tc !== 1'b0) begin
      n_errors++;
      $display("FAIL down_borrow q=%h tc=%b required q=0999 tc=0", q, tc);
    end
    do_load(16'h0000);
    en = 1'b1;
    repeat (10) model_clock();
    en = 1'b0;
    n_checks++;
    if (q !== 16'h9999 || tc !== 1'b1) begin
      n_errors++;
      $display("FAIL down_wrap q=%h tc=%b required q=9999 tc=1", q, tc);
    end
  endtask

  task automatic test_priority();
    en = 1'b1; up_dn = 1'b1;
    repeat (4) model_clock();
    clr = 1'b1; load = 1'b1; load_val = 16'h12F4;
    model_clock();
    clr = 1'b0;
    n_checks++;
    if (q !== 16'h0000 || tick !== 1'b0) begin
      n_errors++;
      $display("FAIL clr_over_load q=%h tick=%b required q=0000 tick=0", q, tick);
    end
    model_clock();
    load = 1'b0;
    n_checks++;
    if (q !== 16'h1294) begin
      n_errors++;
      $display("FAIL load_saturate q=%h required=1294", q);
    end
    for (int c = 1; c <= 10; c++) begin
      model_clock();
      n_checks++;
      if (q !== ((c == 10) ? 16'h1295 : 16'h1294) || tick !== (c == 10)) begin
        n_errors++;
        $display("FAIL load_prescale_restart cycle=%0d q=%h tick=%b", c, q, tick);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_async_reset();
    do_load(16'h0456);
    en = 1'b1; up_dn = 1'b1;
    repeat (10) model_clock();
    en = 1'b0;
    n_checks++;
    if (q !== 16'h0457 || tick !== 1'b1) begin
      n_errors++;
      $display("FAIL async_setup q=%h tick=%b required q=0457 tick=1", q, tick);
    end
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (q !== 16'h0000 || tick !== 1'b0 || tc !== 1'b0) begin
      n_errors++;
      $display("FAIL async_reset q=%h tick=%b tc=%b required q=0000 tick=0 tc=0", q, tick, tc);
    end
    m_cnt = 0; m_pre = 0; m_tick = 0; m_tc = 0;
    @(negedge clk);
    rst = 1'b1;
    model_clock();
    en = 1'b1;
    for (int c = 1; c <= TICK_DIV; c++) begin
      model_clock();
      n_checks++;
      if (q !== ((c == TICK_DIV) ? 16'h0001 : 16'h0000) || tick !== (c == TICK_DIV)) begin
        n_errors++;
        $display("FAIL reset_release_first_step cycle=%0d q=%h tick=%b", c, q, tick);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      en       = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 49) == 0) up_dn = ~up_dn;
      clr      = ($urandom_range(0, 59) == 0);
      load     = ($urandom_range(0, 39) == 0);
      load_val = 16'($urandom);
      if ($urandom_range(0, 3) == 0) load_val = 16'h9999;
      if ($urandom_range(0, 3) == 0) load_val = 16'h0000;
      model_clock();
      n_checks++;
      if (q !== to_bcd(m_cnt) || tick !== m_tick || tc !== m_tc) begin
        n_errors++;
        $display("FAIL random cycle=%0d q=%h tick=%b tc=%b required q=%h tick=%b tc=%b",
                 c, q, tick, tc, to_bcd(m_cnt), m_tick, m_tc);
      end
    end
    en = 1'b0; clr = 1'b0; load = 1'b0;
  endtask

  task automatic test_tickdiv1();
    int tcs, ticks;
    logic [7:0] held;
    tcs = 0; ticks = 0;
    rst2 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst2 = 1'b1;
    en2 = 1'b1; up_dn2 = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      if (tc2 === 1'b1) tcs++;
      if (tick2 === 1'b1) ticks++;
    end
    en2 = 1'b0;
    n_checks++;
    if (q2 !== 8'h00 || tcs != 1 || ticks != 100) begin
      n_errors++;
      $display("FAIL tickdiv1_count q=%h tc_pulses=%0d ticks=%0d required q=00 tc_pulses=1 ticks=100", q2, tcs, ticks);
    end
    en2 = 1'b1;
    repeat (37) @(posedge clk);
    #1;
    en2 = 1'b0;
    held = q2;
    n_checks++;
    if (held !== 8'h37) begin
      n_errors++;
      $display("FAIL tickdiv1_partial q=%h required=37", held);
    end
    repeat (5) begin
      @(posedge clk); #1;
      n_checks++;
      if (q2 !== 8'h37 || tick2 !== 1'b0 || tc2 !== 1'b0) begin
        n_errors++;
        $display("FAIL tickdiv1_hold q=%h tick=%b tc=%b required q=37 tick=0 tc=0", q2, tick2, tc2);
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
    rst2 = 1'b0; en2 = 1'b0; up_dn2 = 1'b1; clr2 = 1'b0; load2 = 1'b0; load_val2 = '0;
    test_reset();
    test_up_count();
    test_up_wrap();
    test_down_borrow();
    test_priority();
    test_async_reset();
    test_random();
    test_tickdiv1();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_decade_counter.md
SYNC_DECADE_COUNTER -- requirements
Module: sync_decade_counter

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of cascaded BCD digits, legal range 1..8.
REQ-002 SHALL have parameter TICK_DIV, default 10, clock cycles per count step, legal range 1..65535.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  count enable, gates the prescaler and counting.
REQ-006 SHALL have port up_dn  input  1  direction: 1 = increment, 0 = decrement.
REQ-007 SHALL have port clr  input  1  synchronous clear of digits and prescaler.
REQ-008 SHALL have port load  input  1  synchronous parallel load.
REQ-009 SHALL have port load_val  input  4*DIGITS  BCD load value, digit i in bits [4i+3:4i].
REQ-010 SHALL have port q  output  4*DIGITS  BCD count, digit 0 (least significant) in bits [3:0].
REQ-011 SHALL have port tick  output  1  registered one-cycle strobe marking each count step.
REQ-012 SHALL have port tc  output  1  registered one-cycle terminal-count (wrap) strobe.

Function
REQ-013 SHALL derive all timing from clk only, with no generated or divided clocks; the prescaler SHALL act as a clock enable.
REQ-014 Prescaler SHALL count 0..TICK_DIV-1 on cycles with en=1, hold when en=0, and wrap to 0 after TICK_DIV-1.
REQ-015 Step condition SHALL be en=1 and prescaler=TICK_DIV-1; with TICK_DIV=1, every cycle with en=1 SHALL be a step.
REQ-016 On a step edge, q SHALL update in that same edge: +1 BCD if up_dn=1, -1 BCD if up_dn=0; zero added latency.
REQ-017 Each digit SHALL stay in 0..9; the up-carry from digit i to digit i+1 SHALL occur when digits 0..i are all 9; the down-borrow SHALL occur when digits 0..i are all 0; all digits SHALL update in the same cycle.
REQ-018 Up wrap SHALL be all-9s -> all-0s; down wrap SHALL be all-0s -> all-9s.
REQ-019 tick SHALL be 1 in the cycle after each step edge, for exactly one cycle; otherwise 0.
REQ-020 tc SHALL be 1 for exactly one cycle, coincident with q first showing the wrapped value; otherwise 0.
REQ-021 Priority SHALL be clr > load > step; up_dn is sampled only on step edges.
REQ-022 clr=1 SHALL set q=0 and prescaler=0 and force tick=0 and tc=0 on the next edge, regardless of en.
REQ-023 load=1 (clr=0) SHALL set q=load_val and prescaler=0, with tick=0 and tc=0; any nibble greater than 9 SHALL load as 9.
REQ-024 A direction change between steps SHALL take effect on the next step without glitching q.
REQ-025 With en=0 and no clr or load, q, the prescaler, tick and tc SHALL hold, with tick and tc reading 0.

Reset
REQ-026 rst=0 SHALL immediately, independent of clk, force q=0, prescaler=0, tick=0 and tc=0.
REQ-027 Release of rst SHALL be synchronous to clk; the first possible step edge SHALL be TICK_DIV enabled cycles after release.
REQ-028 Reset asserted mid-count or mid-strobe SHALL abort the strobe, and the count SHALL restart from 0.

Verification (DIGITS=4, TICK_DIV=10 unless stated)
REQ-029 Up count: reset, en=1, up_dn=1 for 100 cycles -> q=0x0010, 10 tick pulses spaced 10 cycles apart, tc never asserted.
REQ-030 Up wrap: load 0x9999, then en=1 for 10 cycles -> q=0x0000 and tc=1 in the same cycle, for one cycle.
REQ-031 Down and borrow: load 0x1000, up_dn=0, one step -> q=0x0999; load 0x0000 and step -> q=0x9999 with tc=1.
REQ-032 Priority and saturation: clr=1 and load=1 with load_val=0x12F4 -> q=0x0000; then load only -> q=0x1294, prescaler restarts and the next step lands 10 cycles later.
REQ-033 Async reset: assert rst=0 between edges at q=0x0457 with tick high -> q=0x0000 and tick=0 immediately, with no clock edge required.
REQ-034 TICK_DIV=1 with DIGITS=2: en=1 for 100 cycles from 0 -> q=0x00 and one tc; en toggled 0 for 5 cycles -> q holds.
